alu_unsigned_seq: RTL and testbench
===================================

Name: alu_unsigned_seq

Overview:
Parametrised unsigned ALU, successor of the 8-bit unsigned ALU. It keeps the same 4-bit opcode map and adds a valid/ready input handshake.
- Logic, compare, add and subtract complete in one cycle.
- Multiply (shift-add) and divide (restoring) are iterative, so WIDTH can scale without wide combinational arrays.
- Sits between the operand register file and the result writeback stage.

Parameters:
WIDTH, 8, operand width in bits (>= 2); result width is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept an operation this cycle
u_a  input  WIDTH  operand A
u_b  input  WIDTH  operand B
op  input  4  opcode
out_valid  output  1  one-cycle pulse: u_result and flags updated
u_result  output  2*WIDTH  result, held between out_valid pulses
borrow  output  1  subtract underflow (u_a < u_b)
carry  output  1  add overflow out of bit WIDTH-1
div_by_zero  output  1  division attempted with u_b == 0

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 XOR, 0011 NOT (~u_a).
  - 0100 EQ, 0101 GT (a>b), 0110 LT (a<b).
  - 1000 ADD, 1001 SUB, 1010 DIV, 1011 MUL.
  - 0111 and 1100-1111 are illegal.
- Accept: an operation is captured on a rising edge where in_valid && in_ready. u_a, u_b and op are registered at that edge; inputs may change afterwards.
- States:
  - IDLE: in_ready=1.
    - Accepted MUL goes to MUL.
    - Accepted DIV with u_b!=0 goes to DIV.
    - Every other accepted op, including DIV with u_b==0, stays in IDLE and produces its result at the next edge.
  - MUL / DIV: in_ready=0. The counter runs WIDTH iterations, one per clock. On the final iteration the state returns to IDLE and the result is written.
- Latency, counted from the accepting edge E:
  - Single-cycle ops: out_valid high for the cycle after edge E+1.
  - MUL and DIV (u_b!=0): out_valid high after edge E+WIDTH+1.
  - Single-cycle ops may be issued back-to-back every cycle, giving one out_valid per cycle.
- Result formatting (zero-extended to 2*WIDTH unless stated):
  - Logic ops: bitwise result.
  - Compare: bit 0 = 1/0.
  - ADD: {carry, sum}; carry flag also set.
  - SUB: low WIDTH bits of u_a-u_b (mod 2^WIDTH); borrow=1 iff u_a<u_b.
  - MUL: full 2*WIDTH product.
  - DIV: quotient in [WIDTH-1:0]; upper half per Optional Feature.
  - Divide by zero: quotient all ones, div_by_zero=1.
  - Illegal op: result 0, all flags 0.
- Flags: borrow, carry and div_by_zero are updated only on out_valid. Each flag is 0 for any op that does not define it.
- Busy input: in_valid while in_ready=0 is ignored; nothing is queued. The source must hold the operation until in_ready is high.
- Reset (asynchronous, any time, including mid-MUL/DIV):
  - State goes to IDLE and the counter is cleared.
  - u_result=0, out_valid=0, borrow=0, carry=0, div_by_zero=0.
  - in_ready=1 from the first edge after reset deasserts.
  - An in-flight operation is discarded and produces no out_valid.
- out_valid is never high for two consecutive cycles from a single accepted operation.

Optional Feature:
Macro ALU_REMAINDER_EN.
- Defined:
  - DIV places the remainder in u_result[2*WIDTH-1:WIDTH].
  - Divide by zero gives remainder = u_a.
- Not defined: the upper half of the DIV result is 0, and the remainder register and its logic are removed.
- All other ops are identical in both builds.

Test Plan:
- WIDTH=8: AND 0xF0,0x3C, then OR 0xF0,0x3C on the next cycle -> out_valid on two consecutive cycles with u_result 0x0030 then 0x00FC; in_ready stays 1.
- SUB 5,9 -> u_result=0x00FC, borrow=1. Then ADD 0xFF,0x01 -> u_result=0x0100, carry=1, borrow=0.
- MUL 255,255 -> in_ready=0 for 8 cycles; out_valid 9 edges after accept; u_result=0xFE01. in_valid pulses during busy are ignored, with no extra out_valid.
- DIV 200,7 -> quotient 28. u_result=0x041C with ALU_REMAINDER_EN, 0x001C without; latency 9.
- DIV 0x12,0 -> out_valid after 1 edge, div_by_zero=1. u_result=0x12FF with ALU_REMAINDER_EN, 0x00FF without.
- Assert reset 4 cycles into MUL 100,3 -> outputs 0 immediately, no out_valid for the aborted op. After release, EQ 7,7 -> u_result=0x0001.

Source files
------------

// File: rtl/alu_unsigned_seq_if.sv
// Operation/result bundle for alu_unsigned_seq: valid/ready operand side plus result and flags.
// The master drives operands; the slave (the ALU) returns ready, result and flags.
interface alu_unsigned_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     u_a;
    logic [WIDTH-1:0]     u_b;
    logic [3:0]           op;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   u_result;
    logic                 borrow;
    logic                 carry;
    logic                 div_by_zero;

    modport master (
        output in_valid, u_a, u_b, op,
        input  in_ready, out_valid, u_result, borrow, carry, div_by_zero
    );

    modport slave (
        input  in_valid, u_a, u_b, op,
        output in_ready, out_valid, u_result, borrow, carry, div_by_zero
    );
endinterface

// File: rtl/alu_unsigned_seq.sv
// Unsigned ALU with valid/ready input; MUL (shift-add) and DIV (restoring) iterate WIDTH cycles.
// Define ALU_REMAINDER_EN to return the DIV remainder in the upper half of u_result.
//
// state | meaning
// IDLE  | ready; single-cycle ops and div-by-zero go straight to the result stage
// MUL   | shift-add multiply, one bit per clock
// DIV   | restoring divide, one quotient bit per clock
module alu_unsigned_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input logic               clk,
    input logic               reset,
    alu_unsigned_seq_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b0100;
    localparam logic [3:0] OP_GT  = 4'b0101;
    localparam logic [3:0] OP_LT  = 4'b0110;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;
    localparam logic [3:0] OP_DIV = 4'b1010;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 pend;
    logic                 pend_nx;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [3:0]           op_reg;
    logic [WIDTH-1:0]     hi;
    logic [WIDTH-1:0]     lo;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_sh;
    logic [WIDTH:0]       div_diff;
    logic [WIDTH:0]       add_full;
    logic [2*WIDTH-1:0]   res_nx;
    logic                 borrow_nx;
    logic                 carry_nx;
    logic                 dbz_nx;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 borrow_q;
    logic                 carry_q;
    logic                 dbz_q;

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.u_result    = result_q;
    assign bus.borrow      = borrow_q;
    assign bus.carry       = carry_q;
    assign bus.div_by_zero = dbz_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // pend marks that the result stage writes u_result on the next edge.
    always_comb begin
        state_nx = state;
        pend_nx  = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.in_valid;
                if (bus.in_valid) begin
                    if (bus.op == OP_MUL)
                        state_nx = MUL;
                    else if (bus.op == OP_DIV && bus.u_b != '0)
                        state_nx = DIV;
                    else
                        pend_nx = 1'b1;
                end
            end
            MUL, DIV: begin
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                    pend_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, a_reg} : '0);
    assign div_sh   = {hi, lo[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, b_reg};
    assign add_full = {1'b0, a_reg} + {1'b0, b_reg};

    always_comb begin
        res_nx    = '0;
        borrow_nx = 1'b0;
        carry_nx  = 1'b0;
        dbz_nx    = 1'b0;
        case (op_reg)
            OP_AND: res_nx[WIDTH-1:0] = a_reg & b_reg;
            OP_OR:  res_nx[WIDTH-1:0] = a_reg | b_reg;
            OP_XOR: res_nx[WIDTH-1:0] = a_reg ^ b_reg;
            OP_NOT: res_nx[WIDTH-1:0] = ~a_reg;
            OP_EQ:  res_nx[0] = (a_reg == b_reg);
            OP_GT:  res_nx[0] = (a_reg > b_reg);
            OP_LT:  res_nx[0] = (a_reg < b_reg);
            OP_ADD: begin
                res_nx[WIDTH:0] = add_full;
                carry_nx        = add_full[WIDTH];
            end
            OP_SUB: begin
                res_nx[WIDTH-1:0] = a_reg - b_reg;
                borrow_nx         = (a_reg < b_reg);
            end
            OP_MUL: res_nx = {hi, lo};
            OP_DIV: begin
                if (b_reg == '0) begin
                    res_nx[WIDTH-1:0] = '1;
                    dbz_nx            = 1'b1;
`ifdef ALU_REMAINDER_EN
                    res_nx[2*WIDTH-1:WIDTH] = a_reg;
`endif
                end else begin
                    res_nx[WIDTH-1:0] = lo;
`ifdef ALU_REMAINDER_EN
                    res_nx[2*WIDTH-1:WIDTH] = hi;
`endif
                end
            end
            default: res_nx = '0;
        endcase
    end

    // hi/lo hold {partial product, multiplier} for MUL and {partial remainder, quotient} for DIV.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            pend        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            borrow_q    <= 1'b0;
            carry_q     <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            if (accept) begin
                a_reg  <= bus.u_a;
                b_reg  <= bus.u_b;
                op_reg <= bus.op;
                hi     <= '0;
                lo     <= (bus.op == OP_MUL) ? bus.u_b : bus.u_a;
                cnt    <= CNT_W'(WIDTH);
            end else if (state == MUL) begin
                hi  <= mul_sum[WIDTH:1];
                lo  <= {mul_sum[0], lo[WIDTH-1:1]};
                cnt <= cnt - CNT_W'(1);
            end else if (state == DIV) begin
                hi  <= div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
                lo  <= {lo[WIDTH-2:0], ~div_diff[WIDTH]};
                cnt <= cnt - CNT_W'(1);
            end
            pend        <= pend_nx;
            out_valid_q <= pend;
            if (pend) begin
                result_q <= res_nx;
                borrow_q <= borrow_nx;
                carry_q  <= carry_nx;
                dbz_q    <= dbz_nx;
            end
        end
    end
endmodule

// File: tb/tb_alu_unsigned_seq.sv
// Directed bench for alu_unsigned_seq at WIDTH=8 with hand-computed expectations.
// Honors ALU_REMAINDER_EN for the expected upper half of DIV results.
module tb_alu_unsigned_seq;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    alu_unsigned_seq_if #(.WIDTH(8)) bus ();

    alu_unsigned_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits 1ns after a rising edge with in_ready high.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input int lat, input logic [15:0] res,
                          input logic brw, input logic cy, input logic dz);
        int n;
        bus.in_valid = 1'b1;
        bus.op       = o;
        bus.u_a      = a;
        bus.u_b      = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_res"}, {16'h0, bus.u_result}, {16'h0, res});
        check({tag, "_flags"}, {29'h0, bus.borrow, bus.carry, bus.div_by_zero}, {29'h0, brw, cy, dz});
        @(posedge clk); #1;
        check({tag, "_single_pulse"}, {31'h0, bus.out_valid}, 32'h0);
    endtask

    initial begin
        int n;
        int busy;
        int extra;
        logic [15:0] div_exp;
        logic [15:0] dbz_exp;
        logic [15:0] div_small_exp;

        checks        = 0;
        failures      = 0;
        clk           = 1'b0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.u_a       = '0;
        bus.u_b       = '0;
        bus.op        = '0;
`ifdef ALU_REMAINDER_EN
        div_exp       = 16'h041C;
        dbz_exp       = 16'h12FF;
        div_small_exp = 16'h0700;
`else
        div_exp       = 16'h001C;
        dbz_exp       = 16'h00FF;
        div_small_exp = 16'h0000;
`endif

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        check("rst_result", {16'h0, bus.u_result}, 32'h0);
        check("rst_ready", {31'h0, bus.in_ready}, 32'h1);

        // Back-to-back AND then OR.
        bus.in_valid = 1'b1;
        bus.op = 4'b0000; bus.u_a = 8'hF0; bus.u_b = 8'h3C;
        @(posedge clk); #1;
        check("b2b_ready0", {31'h0, bus.in_ready}, 32'h1);
        bus.op = 4'b0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("b2b_valid0", {31'h0, bus.out_valid}, 32'h1);
        check("b2b_and", {16'h0, bus.u_result}, 32'h0030);
        check("b2b_ready1", {31'h0, bus.in_ready}, 32'h1);
        @(posedge clk); #1;
        check("b2b_valid1", {31'h0, bus.out_valid}, 32'h1);
        check("b2b_or", {16'h0, bus.u_result}, 32'h00FC);
        @(posedge clk); #1;
        check("b2b_valid_end", {31'h0, bus.out_valid}, 32'h0);

        run_op("sub_5_9",   4'b1001, 8'h05, 8'h09, 1, 16'h00FC, 1'b1, 1'b0, 1'b0);
        run_op("add_ff_01", 4'b1000, 8'hFF, 8'h01, 1, 16'h0100, 1'b0, 1'b1, 1'b0);
        run_op("add_7f_01", 4'b1000, 8'h7F, 8'h01, 1, 16'h0080, 1'b0, 1'b0, 1'b0);
        run_op("sub_9_5",   4'b1001, 8'h09, 8'h05, 1, 16'h0004, 1'b0, 1'b0, 1'b0);
        run_op("xor",       4'b0010, 8'hAA, 8'h0F, 1, 16'h00A5, 1'b0, 1'b0, 1'b0);
        run_op("not",       4'b0011, 8'h3C, 8'h55, 1, 16'h00C3, 1'b0, 1'b0, 1'b0);
        run_op("gt_true",   4'b0101, 8'h09, 8'h05, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("gt_false",  4'b0101, 8'h05, 8'h09, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("lt_true",   4'b0110, 8'h05, 8'h09, 1, 16'h0001, 1'b0, 1'b0, 1'b0);
        run_op("eq_false",  4'b0100, 8'h03, 8'h04, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("sub_brw",   4'b1001, 8'h00, 8'h01, 1, 16'h00FF, 1'b1, 1'b0, 1'b0);
        run_op("ill_0111",  4'b0111, 8'hFF, 8'hFF, 1, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("ill_1111",  4'b1111, 8'h12, 8'h34, 1, 16'h0000, 1'b0, 1'b0, 1'b0);

        // MUL 255*255 with ignored in_valid pulses while busy.
        bus.in_valid = 1'b1;
        bus.op = 4'b1011; bus.u_a = 8'hFF; bus.u_b = 8'hFF;
        @(posedge clk); #1;
        bus.op = 4'b0000; bus.u_a = 8'h11; bus.u_b = 8'h22;
        n = 0;
        busy = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            if (bus.in_ready === 1'b0) busy++;
            bus.in_valid = (bus.in_ready === 1'b0) && n[0];
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b0;
        check("mul_lat", n, 9);
        check("mul_busy", busy, 8);
        check("mul_res", {16'h0, bus.u_result}, 32'hFE01);
        extra = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        check("mul_no_extra", extra, 0);

        run_op("mul_15_17", 4'b1011, 8'h0F, 8'h11, 9, 16'h00FF, 1'b0, 1'b0, 1'b0);
        run_op("mul_x_0",   4'b1011, 8'hAB, 8'h00, 9, 16'h0000, 1'b0, 1'b0, 1'b0);
        run_op("div_200_7", 4'b1010, 8'd200, 8'd7, 9, div_exp, 1'b0, 1'b0, 1'b0);
        run_op("div_255_1", 4'b1010, 8'hFF, 8'h01, 9, 16'h00FF, 1'b0, 1'b0, 1'b0);
        run_op("div_7_200", 4'b1010, 8'd7, 8'd200, 9, div_small_exp, 1'b0, 1'b0, 1'b0);
        run_op("div_zero",  4'b1010, 8'h12, 8'h00, 1, dbz_exp, 1'b0, 1'b0, 1'b1);

        // Reset 4 cycles into MUL 100*3.
        bus.in_valid = 1'b1;
        bus.op = 4'b1011; bus.u_a = 8'd100; bus.u_b = 8'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("abort_result", {16'h0, bus.u_result}, 32'h0);
        check("abort_flags", {29'h0, bus.borrow, bus.carry, bus.div_by_zero}, 32'h0);
        check("abort_valid", {31'h0, bus.out_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        extra = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) extra++;
        end
        check("abort_no_valid", extra, 0);
        check("abort_ready", {31'h0, bus.in_ready}, 32'h1);
        run_op("eq_7_7", 4'b0100, 8'h07, 8'h07, 1, 16'h0001, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
